// File: rtl/irq_ack_ctrl.sv
// Priority interrupt presenter with ack/eoi handshake and one-hot source clear.
// Define IRQ_ACK_SYNC_EN to add a 2-flop synchroniser ahead of the irq_in register.
module irq_ack_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               cpu_irq,
    output logic [VEC_W-1:0]   cpu_vec,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic [NUM_SRC-1:0] src_clr,
    output logic               in_svc,
    output logic               ack_err
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SERV
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] req;
    logic [VEC_W-1:0]   pick;
    logic [NUM_SRC-1:0] one;

    assign one = {{(NUM_SRC-1){1'b0}}, 1'b1};

`ifdef IRQ_ACK_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            irq_s <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            irq_s <= sync2;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_s <= '0;
        else        irq_s <= irq_in;
    end
`endif

    assign req = irq_s & ~src_mask;

    // Scan downwards so the lowest set index wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) pick = VEC_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cpu_irq <= 1'b0;
            cpu_vec <= '0;
            src_clr <= '0;
            in_svc  <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            src_clr <= '0;
            unique case (state)
                IDLE: begin
                    if (cpu_ack || cpu_eoi) ack_err <= 1'b1;
                    if (|req) begin
                        state   <= PEND;
                        cpu_irq <= 1'b1;
                        cpu_vec <= pick;
                    end
                end
                PEND: begin
                    if (cpu_ack) begin
                        state   <= SERV;
                        cpu_irq <= 1'b0;
                        in_svc  <= 1'b1;
                        src_clr <= one << cpu_vec;
                    end else begin
                        if (cpu_eoi) ack_err <= 1'b1;
                        if (|req) begin
                            cpu_vec <= pick;
                        end else begin
                            state   <= IDLE;
                            cpu_irq <= 1'b0;
                        end
                    end
                end
                SERV: begin
                    if (cpu_ack) ack_err <= 1'b1;
                    if (cpu_eoi) begin
                        state  <= IDLE;
                        in_svc <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
